cypher_ctrl: RTL and testbench

//   Sequencer for the OTP encryption datapath: owns the shifter (seed load,

---
 rtl/cypher_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cypher_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cypher_ctrl.sv
// Sequencer for the OTP datapath: seeds and warms the shifter, steps it once
// per word, and moves words through the registered cypher XOR stage.
module cypher_ctrl #(
  parameter int unsigned W      = 64,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned WARMUP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       seed,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             busy,
  output logic             done,
  output logic             sh_rst,
  output logic             sh_en,
  output logic [7:0]       sh_seed,
  input  logic [W-1:0]     otp,
  output logic [W-1:0]     cy_plaintext,
  input  logic [W-1:0]     cy_ciphertext
);

  localparam int unsigned WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WARM,
    S_ACCEPT,
    S_XOR,
    S_CAPT,
    S_OUT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [7:0]        seed_q, seed_d;
  logic [W-1:0]      pt_q, pt_d;
  logic [W-1:0]      out_data_q, out_data_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sh_rst_q, sh_rst_d;
  logic              sh_en_q, sh_en_d;

  // The keystream is only consumed through the cypher; otp is observed, not used.
  logic unused_otp;
  assign unused_otp = ^otp;

  // Next state and next register values; outputs are decoded from the next state
  // so that every output is a flop that lines up with the state it belongs to.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    warm_d     = warm_q;
    seed_d     = seed_q;
    pt_d       = pt_q;
    out_data_d = out_data_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          seed_d  = seed;
          cnt_d   = msg_len;
          state_d = (msg_len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        warm_d  = '0;
        state_d = S_WARM;
      end
      S_WARM: begin
        if (warm_q == WARM_W'(WARMUP - 1)) begin
          state_d = S_ACCEPT;
        end else begin
          warm_d = warm_q + WARM_W'(1);
        end
      end
      S_ACCEPT: begin
        if (in_valid && in_ready_q) begin
          pt_d    = in_data;
          state_d = S_XOR;
        end
      end
      S_XOR: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        out_data_d = cy_ciphertext;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LEN_W'(1);
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          state_d = (cnt_q == '0) ? S_DONE : S_ACCEPT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over any transition out of a busy state.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end

    in_ready_d  = (state_d == S_ACCEPT);
    out_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    sh_rst_d    = (state_d == S_LOAD);
    sh_en_d     = (state_d == S_WARM) || (state_d == S_CAPT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      warm_q      <= '0;
      seed_q      <= '0;
      pt_q        <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sh_rst_q    <= 1'b0;
      sh_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      warm_q      <= warm_d;
      seed_q      <= seed_d;
      pt_q        <= pt_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sh_rst_q    <= sh_rst_d;
      sh_en_q     <= sh_en_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sh_rst       = sh_rst_q;
  assign sh_en        = sh_en_q;
  assign sh_seed      = seed_q;
  assign cy_plaintext = pt_q;

endmodule

// File: tb/tb_cypher_ctrl.sv
// Randomised bench for cypher_ctrl with an additive-keystream shifter and a
// registered XOR cypher around it; expected ciphertext comes from a closed form.
module tb_cypher_ctrl;

  localparam int W      = 64;
  localparam int LEN_W  = 8;
  localparam int WARMUP = 4;
  localparam logic [63:0] KC = 64'h9E3779B97F4A7C15;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [7:0]       seed;
  logic [LEN_W-1:0] msg_len;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             busy;
  logic             done;
  logic             sh_rst;
  logic             sh_en;
  logic [7:0]       sh_seed;
  logic [W-1:0]     otp;
  logic [W-1:0]     cy_plaintext;
  logic [W-1:0]     cy_ciphertext;

  cypher_ctrl #(.W(W), .LEN_W(LEN_W), .WARMUP(WARMUP)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .msg_len(msg_len),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .sh_rst(sh_rst), .sh_en(sh_en), .sh_seed(sh_seed),
    .otp(otp), .cy_plaintext(cy_plaintext), .cy_ciphertext(cy_ciphertext)
  );

  always #5 clk = ~clk;

  // Shifter: load replicates the seed, each step adds KC. Cypher: one-cycle XOR.
  logic [63:0] sh_state = '0;
  logic [63:0] cy_reg   = '0;
  always @(posedge clk) begin
    if (sh_rst) sh_state <= {8{sh_seed}};
    else if (sh_en) sh_state <= sh_state + KC;
    cy_reg <= cy_plaintext ^ sh_state;
  end
  assign otp           = sh_state;
  assign cy_ciphertext = cy_reg;

  function automatic logic [63:0] ks(input logic [7:0] s, input int n);
    return {8{s}} + 64'(n) * KC;
  endfunction

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  function automatic void check_zero(input string tag);
    check1({tag, "_in_ready"}, in_ready, 1'b0);
    check1({tag, "_out_valid"}, out_valid, 1'b0);
    check1({tag, "_busy"}, busy, 1'b0);
    check1({tag, "_done"}, done, 1'b0);
    check1({tag, "_sh_rst"}, sh_rst, 1'b0);
    check1({tag, "_sh_en"}, sh_en, 1'b0);
    check({tag, "_out_data"}, out_data, 64'h0);
    check({tag, "_sh_seed"}, 64'(sh_seed), 64'h0);
    check({tag, "_cy_pt"}, cy_plaintext, 64'h0);
  endfunction

  logic [63:0] pt_arr [256];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  int sh_en_cnt, sh_rst_cnt, done_cnt, busy_cnt, in_rdy_cnt, ov_cnt;
  int cyc = 0;
  int hs_cyc = -100;
  logic prev_hold = 1'b0, prev_ov = 1'b0, prev_sh_rst = 1'b0;
  logic [63:0] prev_data = '0;

  // Per-cycle comparison of the DUT against the model and stream rules.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      prev_hold = 1'b0; prev_ov = 1'b0; prev_sh_rst = 1'b0;
    end else begin
      if (sh_en) sh_en_cnt++;
      if (sh_rst) sh_rst_cnt++;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (in_ready) in_rdy_cnt++;
      if (out_valid) ov_cnt++;
      if (prev_hold) begin
        check1("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, prev_data);
      end
      if (prev_sh_rst) begin
        check1("sh_rst_width", sh_rst, 1'b0);
        check1("warm_after_load", sh_en, 1'b1);
      end
      if (in_ready || out_valid || sh_en || sh_rst || done) check1("busy_set", busy, 1'b1);
      if (in_ready) check1("ready_excl_valid", out_valid, 1'b0);
      if (in_valid && in_ready) hs_cyc = cyc;
      if (out_valid && !prev_ov) check("latency", 64'(cyc - hs_cyc), 64'd3);
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (exp_q.size() == 0) check("unexpected_word", 64'(exp_q.size()), 64'd1);
        else check("out_data", out_data, exp_q.pop_front());
      end
      prev_hold   = out_valid && !out_ready;
      prev_data   = out_data;
      prev_ov     = out_valid;
      prev_sh_rst = sh_rst;
    end
  end

  task automatic push_model(input logic [7:0] s, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back(pt_arr[i] ^ ks(s, WARMUP + i));
  endtask

  task automatic run_msg(input logic [7:0] s, input int len, input bit bp, input int stall_word,
                         input int abort_word, input bit glitch, input bit rst_mid);
    int k, in_idx, out_idx, stall_left, last_hs, exp_done, ov_before;
    bit fin, abort_pend, glitch_pend, glitched, aborted, rst_hit;
    k = 0; in_idx = 0; out_idx = 0; stall_left = 5; last_hs = -100;
    fin = 0; abort_pend = 0; glitch_pend = 0; glitched = 0; aborted = 0; rst_hit = 0;
    exp_done = (len == 0) ? 1 : 6 + 4 * len + ((stall_word >= 0 && stall_word < len) ? 5 : 0);
    got_q.delete();
    sh_en_cnt = 0; sh_rst_cnt = 0; done_cnt = 0; busy_cnt = 0; in_rdy_cnt = 0; ov_cnt = 0;
    start = 1'b1; seed = s; msg_len = LEN_W'(len);
    @(posedge clk); #1;
    start = 1'b0; seed = 8'($urandom); msg_len = LEN_W'($urandom);
    while (!fin && k < 200 + 40 * len) begin
      in_valid  = (in_idx < len) && (!bp || $urandom_range(3) != 0);
      in_data   = (in_idx < len) ? pt_arr[in_idx] : {$urandom, $urandom};
      out_ready = (out_idx == stall_word && stall_left > 0) ? 1'b0 : (!bp || $urandom_range(1) == 1);
      abort     = abort_pend;
      start     = glitch_pend;
      if (glitch_pend) seed = ~s;
      glitch_pend = 0;
      @(negedge clk);
      k++;
      if (abort) begin
        aborted = 1; fin = 1;
      end else begin
        if (done) begin
          fin = 1;
          if (len > 0) check("done_after_out", 64'(k - last_hs), 64'd1);
          if (!bp) check("done_cycle", 64'(k), 64'(exp_done));
        end
        if (in_valid && in_ready) begin
          if (in_idx == abort_word) abort_pend = 1;
          in_idx++;
        end
        if (out_valid && !out_ready && out_idx == stall_word && stall_left > 0) stall_left--;
        if (out_valid && out_ready) begin
          out_idx++; last_hs = k;
        end
        if (glitch && !glitched && out_valid && !out_ready) begin
          glitch_pend = 1; glitched = 1;
        end
        if (rst_mid && out_valid) begin
          reset = 1'b0; #1;
          check_zero("rst_mid");
          rst_hit = 1; fin = 1;
        end
      end
      @(posedge clk); #1;
    end
    abort = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ov_before = ov_cnt;
    if (!fin) begin
      check("finished", 64'(fin), 64'd1);
      exp_q.delete();
      reset = 1'b0; @(negedge clk); @(posedge clk); #1; reset = 1'b1;
    end else if (aborted) begin
      exp_q.delete();
      @(negedge clk);
      check1("abort_busy", busy, 1'b0);
      check1("abort_in_ready", in_ready, 1'b0);
      check1("abort_out_valid", out_valid, 1'b0);
      check("abort_keeps_pt", cy_plaintext, pt_arr[abort_word]);
      repeat (10) @(posedge clk);
      #1;
      check("abort_no_done", 64'(done_cnt), 64'd0);
      check("abort_no_out", 64'(ov_cnt), 64'(ov_before));
    end else if (rst_hit) begin
      exp_q.delete();
      @(negedge clk);
      check_zero("rst_hold");
      @(posedge clk); #1;
      reset = 1'b1;
    end else begin
      @(negedge clk);
      check1("done_width", done, 1'b0);
      check1("idle_busy", busy, 1'b0);
      @(posedge clk); #1;
      check("words_out", 64'(out_idx), 64'(len));
      check("exp_drained", 64'(exp_q.size()), 64'd0);
      check("sh_seed_held", 64'(sh_seed), 64'(s));
      check("sh_rst_pulses", 64'(sh_rst_cnt), (len > 0) ? 64'd1 : 64'd0);
      check("sh_en_pulses", 64'(sh_en_cnt), (len > 0) ? 64'(WARMUP + len) : 64'd0);
      check("done_pulses", 64'(done_cnt), 64'd1);
      if (!bp) begin
        check("in_ready_cycles", 64'(in_rdy_cnt), 64'(len));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_done));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] orig [4];
    logic [63:0] ct [4];
    logic [63:0] first_w0;
    logic [7:0]  s;
    int          len;

    reset = 1'b0; start = 1'b0; seed = '0; msg_len = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Single word, hand-computed keystream after four warm-up steps.
    pt_arr[0] = 64'h0;
    push_model(8'h33, 1);
    run_msg(8'h33, 1, 0, -1, -1, 0, 0);
    check("single_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check("single_literal_0", got_q[0], 64'hAC111A19305D2387);
    pt_arr[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    push_model(8'h33, 1);
    run_msg(8'h33, 1, 0, -1, -1, 0, 0);
    if (got_q.size() > 0) check("single_literal_1", got_q[0], 64'h53EEE5E6CFA2DC78);

    // Four words with a 5-cycle stall on word 2, then decrypt by re-running.
    s = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      orig[i] = {$urandom, $urandom};
      pt_arr[i] = orig[i];
    end
    push_model(s, 4);
    run_msg(s, 4, 0, 2, -1, 0, 0);
    for (int i = 0; i < 4; i++) ct[i] = (i < got_q.size()) ? got_q[i] : 64'h0;
    for (int i = 0; i < 4; i++) begin
      pt_arr[i] = ct[i];
      exp_q.push_back(orig[i]);
    end
    run_msg(s, 4, 0, -1, -1, 0, 0);

    // Empty message.
    run_msg(8'h5C, 0, 0, -1, -1, 0, 0);

    // Abort during XOR of word 1, then restart with the same seed.
    s = 8'($urandom);
    for (int i = 0; i < 3; i++) pt_arr[i] = {$urandom, $urandom};
    push_model(s, 3);
    run_msg(s, 3, 0, -1, 1, 0, 0);
    check("abort_word0_out", 64'(got_q.size()), 64'd1);
    first_w0 = (got_q.size() > 0) ? got_q[0] : 64'h0;
    exp_q.push_back(first_w0);
    run_msg(s, 1, 0, -1, -1, 0, 0);

    // Start with a different seed while a word waits in OUT.
    s = 8'h96;
    for (int i = 0; i < 3; i++) pt_arr[i] = {$urandom, $urandom};
    push_model(s, 3);
    run_msg(s, 3, 0, 1, -1, 1, 0);

    // Abort together with start in IDLE.
    start = 1'b1; abort = 1'b1; seed = ~sh_seed; msg_len = 8'd3;
    s = sh_seed;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check1("abort_start_busy", busy, 1'b0);
    check1("abort_start_sh_rst", sh_rst, 1'b0);
    check("abort_start_seed", 64'(sh_seed), 64'(s));
    @(posedge clk); #1;

    // Asynchronous reset while a word sits in OUT, then a clean message.
    s = 8'($urandom);
    for (int i = 0; i < 2; i++) pt_arr[i] = {$urandom, $urandom};
    push_model(s, 2);
    run_msg(s, 2, 0, 0, -1, 0, 1);
    s = 8'($urandom);
    push_model(s, 2);
    run_msg(s, 2, 0, -1, -1, 0, 0);

    // Random messages with random source gaps and sink backpressure.
    for (int r = 0; r < 8; r++) begin
      s = 8'($urandom);
      len = $urandom_range(8, 0);
      for (int i = 0; i < len; i++) pt_arr[i] = {$urandom, $urandom};
      push_model(s, len);
      run_msg(s, len, 1, -1, -1, 0, 0);
    end

    // Longest message the length field allows.
    s = 8'($urandom);
    for (int i = 0; i < 255; i++) pt_arr[i] = {$urandom, $urandom};
    push_model(s, 255);
    run_msg(s, 255, 0, -1, -1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
